multi_led_flasher: RTL and testbench

Parametrised N-channel LED driver, successor to the single-channel flasher. Each channel has its own mode-select input that cycles through OFF, ON, FLASH and FAST. A shared PWM brightness setting dims every lit LED. All channels in the same mode flash in phase because they share one timebase. It sits between the debounced button inputs and the board LED pins.

---
 rtl/multi_led_flasher_pkg.sv | 25 ++
 rtl/multi_led_flasher_tick.sv | 32 +++
 rtl/multi_led_flasher.sv | 112 +++++++++++
 tb/tb_multi_led_flasher.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_led_flasher_pkg.sv
// Shared definitions for the multi-channel LED flasher and its neighbours
// (button/debounce blocks, board top level).
//   mode_e       : per-channel LED mode encoding, OFF -> ON -> FLASH -> FAST -> OFF
//   ModeWidth    : bits per mode field
//   next_mode()  : successor in the mode sequence, FAST wraps to OFF
package multi_led_flasher_pkg;

  localparam int unsigned ModeWidth = 2;

  typedef enum logic [ModeWidth-1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeFlash = 2'd2,
    ModeFast  = 2'd3
  } mode_e;

  // Plain modulo-4 increment; relies on the 2-bit field wrapping 3 -> 0.
  function automatic mode_e next_mode(mode_e m);
    logic [ModeWidth-1:0] v;
    v = m;
    v = v + 2'd1;
    return mode_e'(v);
  endfunction

endpackage

// File: rtl/multi_led_flasher_tick.sv
// tick_gen: free-running divider producing a one-cycle pulse every DIV cycles.
//   clk_in : clock, rising edge
//   rst_in : synchronous active-high reset, counter returns to 0
//   tick_o : high for the single cycle in which the counter holds DIV-1
// The counter runs 0..DIV-1; the first pulse is DIV-1 cycles after reset release.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_o
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntMax);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_led_flasher.sv
// multi_led_flasher: N-channel LED driver with per-channel mode cycling and shared PWM dimming.
//   clk_in      : clock, all logic on the rising edge
//   rst_in      : synchronous active-high reset
//   toggle_mode : per-channel level input, each rising edge advances that channel's mode
//   brightness  : shared PWM duty (0 = dark, all-ones = fully on)
//   led_out     : registered LED drive, 1 = lit
//   mode_out    : current mode per channel, channel i in bits [2i+1:2i]
// All channels share one slow and one fast timebase so same-mode channels blink in phase.
module multi_led_flasher
  import multi_led_flasher_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned FLASH_RATE_mHz = 1000,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned PWM_BITS       = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_CH-1:0]             toggle_mode,
  input  logic [PWM_BITS-1:0]           brightness,
  output logic [NUM_CH-1:0]             led_out,
  output logic [ModeWidth*NUM_CH-1:0]   mode_out
);

  // 64-bit arithmetic: CLK_FREQ_HZ * 1000 overflows 32 bits at realistic clock rates.
  localparam longint unsigned HalfL =
      (64'(CLK_FREQ_HZ) * 64'd1000) / (64'd2 * 64'(FLASH_RATE_mHz));
  localparam int unsigned Half    = 32'(HalfL);
  localparam int unsigned FastDiv = Half / 4;

  if (Half < 4) begin : g_half_check
    $error("multi_led_flasher: HALF period must be at least 4 cycles");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_ch_check
    $error("multi_led_flasher: NUM_CH must be 1..16");
  end
  if (PWM_BITS < 2 || PWM_BITS > 8) begin : g_pwm_check
    $error("multi_led_flasher: PWM_BITS must be 2..8");
  end

  logic slow_tick, fast_tick;

  tick_gen #(.DIV(Half)) u_slow_tick (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .tick_o (slow_tick)
  );

  tick_gen #(.DIV(FastDiv)) u_fast_tick (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .tick_o (fast_tick)
  );

  logic                slow_ph_q, fast_ph_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [NUM_CH-1:0]   tog_q;
  logic                pwm_on;

  // All-ones is forced fully on; otherwise the counter compare would leave one dark slot.
  always_comb begin
    pwm_on = (&brightness) | (pwm_cnt_q < brightness);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slow_ph_q <= 1'b0;
      fast_ph_q <= 1'b0;
      pwm_cnt_q <= '0;
      tog_q     <= '1;  // input held high through reset must not count as an edge
    end else begin
      slow_ph_q <= slow_ph_q ^ slow_tick;
      fast_ph_q <= fast_ph_q ^ fast_tick;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      tog_q     <= toggle_mode;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e mode_q, mode_d;
    logic  led_q, led_d;

    always_comb begin
      mode_d = mode_q;
      if (toggle_mode[i] && !tog_q[i]) begin
        mode_d = next_mode(mode_q);
      end
      led_d = 1'b0;
      unique case (mode_q)
        ModeOff:   led_d = 1'b0;
        ModeOn:    led_d = pwm_on;
        ModeFlash: led_d = slow_ph_q & pwm_on;
        ModeFast:  led_d = fast_ph_q & pwm_on;
        default:   led_d = 1'b0;
      endcase
    end

    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        mode_q <= ModeOff;
        led_q  <= 1'b0;
      end else begin
        mode_q <= mode_d;
        led_q  <= led_d;
      end
    end

    assign led_out[i]                       = led_q;
    assign mode_out[ModeWidth*i +: ModeWidth] = mode_q;
  end

endmodule

// File: tb/tb_multi_led_flasher.sv
// Self-checking bench for multi_led_flasher: a cycle-count reference model pushes the expected
// outputs after every clock edge into a queue; a monitor pops and compares on the falling edge.
module tb_multi_led_flasher;

  localparam int unsigned ClkHz  = 1000;
  localparam int unsigned RateMh = 1000;
  localparam int unsigned NCh    = 4;
  localparam int unsigned PBits  = 4;
  localparam int Half  = 500;   // 1000 * 1000 / (2 * 1000)
  localparam int Quart = 125;
  localparam int PMax  = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCh-1:0]   tog;
  logic [PBits-1:0] br;
  logic [NCh-1:0]   led_out;
  logic [2*NCh-1:0] mode_out;

  int n_cmp  = 0;
  int n_fail = 0;

  multi_led_flasher #(
    .CLK_FREQ_HZ    (ClkHz),
    .FLASH_RATE_mHz (RateMh),
    .NUM_CH         (NCh),
    .PWM_BITS       (PBits)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .toggle_mode (tog),
    .brightness  (br),
    .led_out     (led_out),
    .mode_out    (mode_out)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [2*NCh-1:0] mode;
    logic [NCh-1:0]   led;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: t = number of clock edges since reset release.
  // slow phase = (t / HALF) odd, fast phase = (t / (HALF/4)) odd, PWM count = t mod 16.
  initial begin : model
    int t;
    int mode[NCh];
    bit prev[NCh];
    bit led[NCh];
    exp_t e;
    t = 0;
    for (int i = 0; i < NCh; i++) begin
      mode[i] = 0; prev[i] = 1'b1; led[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      if (rst) begin
        t = 0;
        for (int i = 0; i < NCh; i++) begin
          mode[i] = 0; prev[i] = 1'b1; led[i] = 1'b0;
        end
      end else begin
        bit on, slow, fast;
        on   = (int'(br) == PMax) || ((t % 16) < int'(br));
        slow = ((t / Half) % 2) == 1;
        fast = ((t / Quart) % 2) == 1;
        for (int i = 0; i < NCh; i++) begin
          case (mode[i])
            1: led[i] = on;
            2: led[i] = slow && on;
            3: led[i] = fast && on;
            default: led[i] = 1'b0;
          endcase
          if (tog[i] && !prev[i]) mode[i] = (mode[i] + 1) % 4;
          prev[i] = tog[i];
        end
        t++;
      end
      for (int i = 0; i < NCh; i++) begin
        e.mode[2*i +: 2] = 2'(mode[i]);
        e.led[i]         = led[i];
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (mode_out !== e.mode) begin
          n_fail++;
          $display("FAIL mode_out @%0t: got %b expected %b", $time, mode_out, e.mode);
        end
        n_cmp++;
        if (led_out !== e.led) begin
          n_fail++;
          $display("FAIL led_out @%0t: got %b expected %b", $time, led_out, e.led);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic pulse(input int ch);
    tog[ch] = 1'b1;
    step(1);
    tog[ch] = 1'b0;
    step(3);
  endtask

  initial begin : stim
    int highs;
    int waited;
    rst = 1'b1;
    tog = 4'b0001;
    br  = 4'd15;
    step(3);
    rst = 1'b0;
    step(10);
    check("no_advance_held_high", int'(mode_out), 0);
    check("led_dark_after_reset", int'(led_out), 0);
    tog = '0;
    step(2);

    // ch0 cycles 1,2,3,0
    for (int m = 1; m <= 4; m++) begin
      pulse(0);
      check("ch0_mode_seq", int'(mode_out[1:0]), m % 4);
    end

    // ch0 ON, dimmed
    pulse(0);
    br = 4'd4;
    step(20);
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      highs += int'(led_out[0]);
    end
    check("duty_4_of_16", highs, 4);
    br = 4'd0;
    step(2);
    highs = 0;
    for (int k = 0; k < 32; k++) begin
      step(1);
      highs += int'(led_out[0]);
    end
    check("duty_zero", highs, 0);

    // ch1 FLASH, ch2 FAST, full brightness
    br = 4'd15;
    pulse(1); pulse(1);
    pulse(2); pulse(2); pulse(2);
    check("ch1_flash", int'(mode_out[3:2]), 2);
    check("ch2_fast", int'(mode_out[5:4]), 3);
    step(1200);

    // Randomised toggles and brightness
    for (int k = 0; k < 3000; k++) begin
      tog = 4'($urandom & $urandom & $urandom);
      if ((k % 64) == 0) br = 4'($urandom_range(0, 15));
      step(1);
    end

    // Simultaneous edges from OFF
    tog = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    tog = 4'b1111;
    step(1);
    check("all_ch_advance", int'(mode_out), 8'b0101_0101);
    tog = '0;
    step(2);

    // Reset while ch1 is flashing and lit
    br = 4'd15;
    pulse(1);
    waited = 0;
    while (!led_out[1] && waited < 1200) begin
      step(1);
      waited++;
    end
    check("flash_lit_seen", int'(led_out[1]), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_led_zero", int'(led_out), 0);
    check("rst_mode_zero", int'(mode_out), 0);
    pulse(1); pulse(1);
    step(1100);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
